// File: rtl/multicycle_controller.sv
// Sequencing FSM for the multi-cycle RV32I core. Walks each instruction
// through fetch/decode/execute/memory/writeback and drives every datapath
// select and write strobe. Unsupported opcodes park the FSM in TRAP with a
// sticky illegal flag until reset.
//
// Memory handshake: a request (mem_read or mem_write, with adr_src) is held
// constant from the first cycle of a memory state until the cycle in which
// mem_ready=1; that cycle completes the access and the FSM leaves the state
// on the following edge, so the request drops the cycle after. mem_ready is
// ignored in every non-memory state.
module multicycle_controller (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_read,
    output logic       mem_write,
    output logic       adr_src,
    output logic       ir_write,
    output logic       pc_write,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [3:0] alu_control,
    output logic [2:0] imm_src,
    output logic [1:0] result_src,
    output logic       reg_write,
    output logic       illegal,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_JALR_A   = 4'd11,
        S_JALR_B   = 4'd12,
        S_LUI      = 4'd13,
        S_AUIPC    = 4'd14,
        S_TRAP     = 4'd15
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_SLL  = 4'b0010;
    localparam logic [3:0] ALU_SLT  = 4'b0011;
    localparam logic [3:0] ALU_SLTU = 4'b0100;
    localparam logic [3:0] ALU_XOR  = 4'b0101;
    localparam logic [3:0] ALU_SRL  = 4'b0110;
    localparam logic [3:0] ALU_SRA  = 4'b0111;
    localparam logic [3:0] ALU_OR   = 4'b1000;
    localparam logic [3:0] ALU_AND  = 4'b1001;

    state_t cur, nxt;

    // Raw strobes before the reset gate.
    logic mem_read_c, mem_write_c, ir_write_c, pc_write_c, reg_write_c;

    // ALU op for R-type and OP-IMM; funct7b5 selects SUB only for R-type.
    function automatic logic [3:0] arith_op(input logic [2:0] f3,
                                            input logic       f7b5,
                                            input logic       is_r);
        logic [3:0] op;
        case (f3)
            3'b000:  op = (is_r && f7b5) ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = f7b5 ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

    // Immediate format depends on the opcode alone.
    always_comb begin
        case (opcode)
            OP_LOAD, OP_JALR, OP_I: imm_src = 3'b000;
            OP_STORE:               imm_src = 3'b001;
            OP_BRANCH:              imm_src = 3'b010;
            OP_LUI, OP_AUIPC:       imm_src = 3'b011;
            OP_JAL:                 imm_src = 3'b100;
            default:                imm_src = 3'b000;
        endcase
    end

    // Next-state and per-state datapath controls.
    always_comb begin
        nxt         = cur;
        mem_read_c  = 1'b0;
        mem_write_c = 1'b0;
        ir_write_c  = 1'b0;
        pc_write_c  = 1'b0;
        reg_write_c = 1'b0;
        adr_src     = 1'b0;
        alu_src_a   = 2'b00;
        alu_src_b   = 2'b00;
        alu_control = ALU_ADD;
        result_src  = 2'b00;
        case (cur)
            S_FETCH: begin
                mem_read_c = 1'b1;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                if (mem_ready) begin
                    ir_write_c = 1'b1;
                    pc_write_c = 1'b1;
                    nxt        = S_DECODE;
                end
            end
            S_DECODE: begin
                // Precompute branch/JAL target into ALUOut.
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                case (opcode)
                    OP_LOAD, OP_STORE: nxt = (funct3 == 3'b010) ? S_MEMADR : S_TRAP;
                    OP_R:              nxt = S_EXECR;
                    OP_I:              nxt = S_EXECI;
                    OP_BRANCH:         nxt = S_BRANCH;
                    OP_JAL:            nxt = S_JAL;
                    OP_JALR:           nxt = S_JALR_A;
                    OP_LUI:            nxt = S_LUI;
                    OP_AUIPC:          nxt = S_AUIPC;
                    default:           nxt = S_TRAP;
                endcase
            end
            S_MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                nxt       = (opcode == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                mem_read_c = 1'b1;
                adr_src    = 1'b1;
                if (mem_ready) nxt = S_MEMWB;
            end
            S_MEMWB: begin
                result_src  = 2'b01;
                reg_write_c = 1'b1;
                nxt         = S_FETCH;
            end
            S_MEMWRITE: begin
                mem_write_c = 1'b1;
                adr_src     = 1'b1;
                if (mem_ready) nxt = S_FETCH;
            end
            S_EXECR: begin
                alu_src_a   = 2'b10;
                alu_control = arith_op(funct3, funct7b5, 1'b1);
                nxt         = S_ALUWB;
            end
            S_EXECI: begin
                alu_src_a   = 2'b10;
                alu_src_b   = 2'b01;
                alu_control = arith_op(funct3, funct7b5, 1'b0);
                nxt         = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write_c = 1'b1;
                nxt         = S_FETCH;
            end
            S_BRANCH: begin
                // Target sits in ALUOut; pc_write follows zero combinationally.
                alu_src_a = 2'b10;
                case (funct3)
                    3'b000: begin alu_control = ALU_SUB;  pc_write_c = zero;  end
                    3'b001: begin alu_control = ALU_SUB;  pc_write_c = !zero; end
                    3'b100: begin alu_control = ALU_SLT;  pc_write_c = !zero; end
                    3'b101: begin alu_control = ALU_SLT;  pc_write_c = zero;  end
                    3'b110: begin alu_control = ALU_SLTU; pc_write_c = !zero; end
                    3'b111: begin alu_control = ALU_SLTU; pc_write_c = zero;  end
                    default: pc_write_c = 1'b0;
                endcase
                nxt = S_FETCH;
            end
            S_JAL: begin
                // PC <- target in ALUOut while ALU forms the link address.
                pc_write_c = 1'b1;
                alu_src_a  = 2'b01;
                alu_src_b  = 2'b10;
                nxt        = S_ALUWB;
            end
            S_JALR_A: begin
                alu_src_a  = 2'b10;
                alu_src_b  = 2'b01;
                result_src = 2'b10;
                pc_write_c = 1'b1;
                nxt        = S_JALR_B;
            end
            S_JALR_B: begin
                alu_src_a   = 2'b01;
                alu_src_b   = 2'b10;
                result_src  = 2'b10;
                reg_write_c = 1'b1;
                nxt         = S_FETCH;
            end
            S_LUI: begin
                alu_src_a = 2'b11;
                alu_src_b = 2'b01;
                nxt       = S_ALUWB;
            end
            S_AUIPC: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                nxt       = S_ALUWB;
            end
            default: begin
                nxt = S_TRAP;
            end
        endcase
    end

    // State register and sticky trap flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur     <= S_FETCH;
            illegal <= 1'b0;
        end else begin
            cur <= nxt;
            if (nxt == S_TRAP) illegal <= 1'b1;
        end
    end

    // No write strobe or request may escape while reset is held.
    assign mem_read  = mem_read_c  & rst_n;
    assign mem_write = mem_write_c & rst_n;
    assign ir_write  = ir_write_c  & rst_n;
    assign pc_write  = pc_write_c  & rst_n;
    assign reg_write = reg_write_c & rst_n;
    assign state     = cur;

endmodule
